ifetch_unit: RTL

Instruction-fetch and PC-sequencing unit for the RISC-V core. It owns the program counter, fetches one instruction per transaction from instruction memory over a req/ack handshake, and presents it to decode/execute with a valid/ready handshake. It consumes the ALU's branch outputs (`zero`, `alu_result`) to compute the next PC, so it is the consumer end of the ALU's branch/jump result interface.

---
 rtl/ifetch_unit.sv | 110 +++++++++++
 1 files changed

// File: rtl/ifetch_unit.sv
// Instruction-fetch / PC-sequencing unit: fetches over a req/ack memory port,
// issues over valid/ready, and picks the next PC from the ALU branch outputs.
module ifetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] inst,
    output logic        inst_valid,
    input  logic        inst_ready,
    input  logic        zero,
    input  logic [31:0] alu_result,
    output logic [31:0] pc,
    output logic [31:0] pc_plus4,
    output logic        fetch_err
);

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        ISSUE = 2'd1,
        ERR   = 2'd2
    } state_t;

    localparam logic [6:0]  OP_JALR = 7'b110_0111;
    localparam logic [31:0] NOP     = 32'h0000_0013;

    state_t      state, state_nx;
    logic [31:0] pc_nx, inst_nx, next_pc;
    logic        req_nx, valid_nx, err_nx;

    assign imem_addr = pc;
    assign pc_plus4  = pc + 32'd4;

    always_comb begin
        if (inst[6:0] == OP_JALR) begin
            next_pc = alu_result & ~32'h1;
        end else if (zero) begin
            next_pc = pc + alu_result;
        end else begin
            next_pc = pc_plus4;
        end
    end

    always_comb begin
        state_nx = state;
        pc_nx    = pc;
        inst_nx  = inst;
        req_nx   = imem_req;
        valid_nx = inst_valid;
        err_nx   = fetch_err;
        case (state)
            FETCH: begin
                // req is low only for the cycle right after reset; ack is ignored then
                if (!imem_req) begin
                    req_nx = 1'b1;
                end else if (imem_ack) begin
                    inst_nx  = imem_rdata;
                    req_nx   = 1'b0;
                    valid_nx = 1'b1;
                    state_nx = ISSUE;
                end
            end
            ISSUE: begin
                if (inst_ready) begin
                    valid_nx = 1'b0;
                    if (next_pc[1:0] == 2'b00) begin
                        pc_nx    = next_pc;
                        req_nx   = 1'b1;
                        state_nx = FETCH;
                    end else begin
                        err_nx   = 1'b1;
                        state_nx = ERR;
                    end
                end
            end
            ERR: begin
                state_nx = ERR;
            end
            default: begin
                state_nx = ERR;
                err_nx   = 1'b1;
                req_nx   = 1'b0;
                valid_nx = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= FETCH;
            pc         <= RESET_PC;
            inst       <= NOP;
            imem_req   <= 1'b0;
            inst_valid <= 1'b0;
            fetch_err  <= 1'b0;
        end else begin
            state      <= state_nx;
            pc         <= pc_nx;
            inst       <= inst_nx;
            imem_req   <= req_nx;
            inst_valid <= valid_nx;
            fetch_err  <= err_nx;
        end
    end

endmodule
